mmio_uart_tx: RTL
=================

Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, downstream of the CPU alongside the data memory.
- Decodes AddressBus/ControlBus, buffers written bytes in a FIFO, and serialises them 8N1, LSB first, on Tx.
- Provides read data and a select flag so the system muxes PeriphDataOut over the memory output when PeriphSel=1.

Parameters:
- BASE_ADDR, 32'hFFFF_0000, word-aligned base of the 16-byte register window.
- CLKS_PER_BIT, 16, InputClk cycles per serial bit (>=2).
- FIFO_DEPTH, 8, byte FIFO depth (power of 2, 2..128).

Ports:
- InputClk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- AddressBus  in  32  CPU byte address.
- DataBusOut  in  32  CPU store data; only [7:0] is used.
- ControlBus  in  11  [1]=MemReadEn, [2]=MemWriteEn, [6:3] loadtype and [10:7] storetype (ignored).
- PeriphDataOut  out  32  read data, combinational.
- PeriphSel  out  1  high when AddressBus[31:4]==BASE_ADDR[31:4], combinational.
- Tx  out  1  serial line; idles high.
- TxIrq  out  1  level interrupt.

Behaviour:
- Register map (offset = AddressBus[3:2]):
  - 0 TXDATA: write pushes [7:0]; reads 0.
  - 1 STATUS, read-only:
    - bit0 full, bit1 empty, bit2 busy (FSM not IDLE), bit3 overflow (sticky).
    - [11:4] FIFO count; rest 0.
  - 2 CTRL:
    - bit0 tx_en, bit3 irq_en; read back, others 0.
    - Writing bit1=1 clears overflow (W1C, bit1 not stored).
  - 3: reads 0, writes ignored.
- Access qualifiers:
  - Write: PeriphSel & MemWriteEn, sampled at posedge.
  - Read: PeriphDataOut valid while PeriphSel & MemReadEn, else 0.
  - AddressBus[1:0] ignored.
- Reset (async, rst=0):
  - FIFO empty, count 0, overflow 0, CTRL 0, FSM IDLE, baud counter 0.
  - Tx=1, TxIrq=0.
  - Reset mid-frame aborts the frame; Tx goes high immediately.
- FIFO:
  - Push to TXDATA when count==FIFO_DEPTH: byte dropped, overflow set.
  - Fullness is judged on the pre-edge count, so a same-cycle pop does not rescue the push.
  - Simultaneous push and pop with 0<count<FIFO_DEPTH: count unchanged, order preserved.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when tx_en & !empty. Head byte popped into the shift register on that edge; Tx=0.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, each held CLKS_PER_BIT cycles, bit index 0..7.
  - STOP: Tx=1 for CLKS_PER_BIT cycles.
  - STOP exit: if tx_en & !empty, go straight to START and pop (no idle gap); else IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Clearing tx_en mid-frame completes the current frame; no further pops.
- Latency: a write accepted at edge N makes count=1 after N; with tx_en=1, Tx falls after edge N+1.
- TxIrq = irq_en & empty & (state==IDLE), registered (one cycle after the condition).

Optional Feature:
- MMIO_UART_PARITY_EN defined:
  - Adds a PARITY state between DATA and STOP.
  - The parity bit is even parity (XOR of the 8 data bits), or odd when CTRL bit2=1.
  - Frame becomes 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state, CTRL bit2 reads 0 and is not writable, frame is 10 bit times.

Decomposition:
- Shared package mmio_uart_pkg holds:
  - register offsets (TXDATA=0, STATUS=1, CTRL=2)
  - STATUS/CTRL bit indices
  - FSM state encoding
  - ControlBus field indices (READ_EN=1, WRITE_EN=2)
- Sub-module uart_tx_fifo: synchronous byte FIFO with push/pop/full/empty/count and the same async active-low reset.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
1. Reset, then read STATUS -> 0x0000_0002; Tx=1, TxIrq=0; read CTRL -> 0.
2. Write CTRL=0x1, write TXDATA=0x55:
   - Tx falls the edge after the accepting edge; bits 0,1,0,1,0,1,0,1,0,1 each 4 cycles (40 total).
   - STATUS bit2=1 during the frame; Tx=1 after.
3. tx_en=0, write 9 bytes 0x01..0x09 -> STATUS 0x0000_0089 (count 8, full, overflow).
   - Then tx_en=1 -> 8 back-to-back frames 0x01..0x08, 320 cycles with no gap; 0x09 never sent.
4. With overflow set, write CTRL=0x3 -> STATUS bit3 cleared, tx_en stays 1; write CTRL=0x1 -> overflow unchanged.
5. Start frame 0xA5, assert rst=0 at cycle 13 of the frame -> Tx=1 immediately, STATUS=0x2 after release, no residual bits.
6. Write 0xAA to address BASE_ADDR+0x10 -> PeriphSel=0, PeriphDataOut=0, count stays 0.
   - Also: irq_en=1 with empty FIFO and IDLE -> TxIrq=1 within one cycle.

Source files
------------

// File: rtl/mmio_uart_pkg.sv
// Purpose: shared register map, bit positions, bus field indices and FSM encoding for mmio_uart_tx.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mmio_uart_pkg;

    // Register offsets, selected by AddressBus[3:2]
    localparam logic [1:0] REG_TXDATA = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    // STATUS bit positions
    localparam int STAT_FULL      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_BUSY      = 2;
    localparam int STAT_OVF       = 3;
    localparam int STAT_COUNT_LSB = 4;

    // CTRL bit positions
    localparam int CTRL_TX_EN   = 0;
    localparam int CTRL_OVF_CLR = 1;   // write-one-to-clear overflow, not stored
    localparam int CTRL_PAR_ODD = 2;   // only meaningful in parity builds
    localparam int CTRL_IRQ_EN  = 3;

    // ControlBus field indices
    localparam int CB_READ_EN  = 1;
    localparam int CB_WRITE_EN = 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } tx_state_e;

    function automatic logic [31:0] status_word(input logic       full,
                                                input logic       empty,
                                                input logic       busy,
                                                input logic       ovf,
                                                input logic [7:0] count);
        logic [31:0] w;
        w                                   = '0;
        w[STAT_FULL]                        = full;
        w[STAT_EMPTY]                       = empty;
        w[STAT_BUSY]                        = busy;
        w[STAT_OVF]                         = ovf;
        w[STAT_COUNT_LSB+7:STAT_COUNT_LSB]  = count;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Purpose: synchronous byte FIFO (push/pop/full/empty/count), head byte visible combinationally.
// Latency: a push is visible on o_head_dat / o_count after the accepting edge.
// Backpressure: push while full and pop while empty are ignored; the caller judges overflow from o_full.
// Ports: i_clk, i_rst_n (async active-low), i_push/i_push_dat, i_pop, o_head_dat, o_full, o_empty, o_count.
module uart_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [7:0]               i_push_dat,
    input  logic                     i_pop,
    output logic [7:0]               o_head_dat,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full     = (r_count == (AW+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_head_dat = r_mem[r_rd_ptr];

    // Both guards use the pre-edge count, so a same-cycle pop never frees room for a push into a full FIFO.
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop  & ~o_empty;

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Purpose: memory-mapped 8N1 UART transmitter (TXDATA/STATUS/CTRL window) with byte FIFO and level IRQ.
// Latency: write at edge N -> count=1 after N; with tx_en, Tx falls after N+1; frame = 10 (11 with parity) bit times.
// Backpressure: none on the bus; pushes into a full FIFO are dropped and set sticky overflow.
// Ports: InputClk, rst (async active-low), AddressBus/DataBusOut/ControlBus (CPU bus),
//        PeriphDataOut/PeriphSel (read mux), Tx (serial out, idles high), TxIrq (level irq).
// Build option: define MMIO_UART_PARITY_EN to add a parity bit (even, or odd with CTRL bit2).
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        InputClk,
    input  logic        rst,
    input  logic [31:0] AddressBus,
    input  logic [31:0] DataBusOut,
    input  logic [10:0] ControlBus,
    output logic [31:0] PeriphDataOut,
    output logic        PeriphSel,
    output logic        Tx,
    output logic        TxIrq
);
    localparam int             CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int             BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    // Bus decode
    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_push;
    logic        w_ctrl_wr;

    // FIFO interface
    logic [7:0]  w_head_dat;
    logic        w_full;
    logic        w_empty;
    logic [CW-1:0] w_count;
    logic        w_pop;

    // Registers
    logic        r_tx_en;
    logic        r_irq_en;
    logic        r_ovf;
    tx_state_e   r_state;
    logic [BW-1:0] r_baud_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_irq;

    // FSM next values
    tx_state_e   w_state_nxt;
    logic [BW-1:0] w_baud_nxt;
    logic [2:0]  w_bit_nxt;
    logic [7:0]  w_shift_nxt;
    logic        w_tx_nxt;
    logic        w_baud_done;
    logic        w_can_start;

    logic [31:0] w_ctrl_rd;
    logic        w_unused_bits;

    assign w_off     = AddressBus[3:2];
    assign PeriphSel = (AddressBus[31:4] == BASE_ADDR[31:4]);
    assign w_wr      = PeriphSel & ControlBus[CB_WRITE_EN];
    assign w_rd      = PeriphSel & ControlBus[CB_READ_EN];
    assign w_push    = w_wr & (w_off == REG_TXDATA);
    assign w_ctrl_wr = w_wr & (w_off == REG_CTRL);

    assign w_unused_bits = &{1'b0, AddressBus[1:0], DataBusOut[31:8], ControlBus[10:3], ControlBus[0]};

    uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk      (InputClk),
        .i_rst_n    (rst),
        .i_push     (w_push),
        .i_push_dat (DataBusOut[7:0]),
        .i_pop      (w_pop),
        .o_head_dat (w_head_dat),
        .o_full     (w_full),
        .o_empty    (w_empty),
        .o_count    (w_count)
    );

`ifdef MMIO_UART_PARITY_EN
    logic r_par_odd;
    logic r_par_bit;
    logic w_par_nxt;
`endif

    // CTRL register and sticky overflow
    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            r_tx_en  <= 1'b0;
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
            r_par_odd <= 1'b0;
`endif
        end else begin
            if (w_ctrl_wr) begin
                r_tx_en  <= DataBusOut[CTRL_TX_EN];
                r_irq_en <= DataBusOut[CTRL_IRQ_EN];
`ifdef MMIO_UART_PARITY_EN
                r_par_odd <= DataBusOut[CTRL_PAR_ODD];
`endif
            end
            if (w_push && w_full) begin
                r_ovf <= 1'b1;
            end else if (w_ctrl_wr && DataBusOut[CTRL_OVF_CLR]) begin
                r_ovf <= 1'b0;
            end
        end
    end

    // Transmit FSM: next state, baud/bit counters, shift register and the registered Tx level
    assign w_baud_done = (r_baud_cnt == BAUD_LAST);
    assign w_can_start = r_tx_en & ~w_empty;

    always_comb begin
        w_state_nxt = r_state;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        w_baud_nxt  = (r_state == S_IDLE || w_baud_done) ? '0 : r_baud_cnt + 1'b1;
`ifdef MMIO_UART_PARITY_EN
        w_par_nxt   = r_par_bit;
`endif

        case (r_state)
            S_IDLE: begin
                if (w_can_start) w_pop = 1'b1;
            end
            S_START: begin
                if (w_baud_done) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            S_DATA: begin
                if (w_baud_done) begin
                    if (r_bit_idx == 3'd7) begin
`ifdef MMIO_UART_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt   = r_bit_idx + 3'd1;
                        w_shift_nxt = r_shift >> 1;
                    end
                end
            end
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: begin
                if (w_baud_done) w_state_nxt = S_STOP;
            end
`endif
            S_STOP: begin
                // Chaining straight into the next START keeps back-to-back frames gap-free.
                if (w_baud_done) begin
                    if (w_can_start) w_pop = 1'b1;
                    else             w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_pop) begin
            w_state_nxt = S_START;
            w_baud_nxt  = '0;
            w_shift_nxt = w_head_dat;
`ifdef MMIO_UART_PARITY_EN
            w_par_nxt   = (^w_head_dat) ^ r_par_odd;
`endif
        end

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
`ifdef MMIO_UART_PARITY_EN
            S_PARITY: w_tx_nxt = w_par_nxt;
`endif
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge InputClk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= 3'd0;
            r_shift    <= 8'd0;
            r_tx       <= 1'b1;
            r_irq      <= 1'b0;
`ifdef MMIO_UART_PARITY_EN
            r_par_bit  <= 1'b0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_baud_cnt <= w_baud_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_tx       <= w_tx_nxt;
            r_irq      <= r_irq_en & w_empty & (r_state == S_IDLE);
`ifdef MMIO_UART_PARITY_EN
            r_par_bit  <= w_par_nxt;
`endif
        end
    end

    assign Tx    = r_tx;
    assign TxIrq = r_irq;

    // Read mux
    always_comb begin
        w_ctrl_rd              = '0;
        w_ctrl_rd[CTRL_TX_EN]  = r_tx_en;
        w_ctrl_rd[CTRL_IRQ_EN] = r_irq_en;
`ifdef MMIO_UART_PARITY_EN
        w_ctrl_rd[CTRL_PAR_ODD] = r_par_odd;
`endif
    end

    always_comb begin
        PeriphDataOut = '0;
        if (w_rd) begin
            case (w_off)
                REG_STATUS: PeriphDataOut = status_word(w_full, w_empty, (r_state != S_IDLE),
                                                        r_ovf, 8'(w_count));
                REG_CTRL:   PeriphDataOut = w_ctrl_rd;
                default:    PeriphDataOut = '0;
            endcase
        end
    end

endmodule
